// File: rtl/lsu_stb_drain.sv
// Store-buffer drain controller: issues the oldest buffered store to the data
// cache, holds it until acknowledged, then pops the head entry.
module lsu_stb_drain #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stb_empty,
  input  logic [ADDR_W-1:0]   stb_head_addr,
  input  logic [DATA_W-1:0]   stb_head_data,
  input  logic [DATA_W/8-1:0] stb_head_sel,
  output logic                stb_rd_en,
  output logic                stb2dcache_req,
  output logic                stb2dcache_w_en,
  output logic [ADDR_W-1:0]   stb2dcache_addr,
  output logic [DATA_W-1:0]   stb2dcache_wdata,
  output logic [DATA_W/8-1:0] stb2dcache_sel,
  input  logic                dcache2stb_ack,
  input  logic                lsu_ld_req,
  input  logic                flush_req,
  output logic                flush_done,
  output logic                drain_busy,
  output logic [CNT_W-1:0]    drain_cnt
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic {
    DR_IDLE = 1'b0,
    DR_REQ  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                req_q, req_d;
  logic                w_en_q, w_en_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                start;
  logic                ack_hit;

  // A pending fence overrides load priority so it can never be starved.
  assign start   = (state_q == DR_IDLE) && !stb_empty && (!lsu_ld_req || flush_req);
  assign ack_hit = (state_q == DR_REQ) && dcache2stb_ack;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    w_en_d  = w_en_q;
    busy_d  = busy_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      DR_IDLE: begin
        if (start) begin
          addr_d  = stb_head_addr;
          wdata_d = stb_head_data;
          sel_d   = stb_head_sel;
          req_d   = 1'b1;
          w_en_d  = 1'b1;
          busy_d  = 1'b1;
          state_d = DR_REQ;
        end
      end
      DR_REQ: begin
        if (dcache2stb_ack) begin
          req_d   = 1'b0;
          w_en_d  = 1'b0;
          busy_d  = 1'b0;
          state_d = DR_IDLE;
          if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = DR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DR_IDLE;
      req_q   <= 1'b0;
      w_en_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      w_en_q  <= w_en_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  // A reset landing on the ack cycle must not pop: the entry is re-issued.
  assign stb_rd_en        = ack_hit && !rst;
  assign stb2dcache_req   = req_q;
  assign stb2dcache_w_en  = w_en_q;
  assign stb2dcache_addr  = addr_q;
  assign stb2dcache_wdata = wdata_q;
  assign stb2dcache_sel   = sel_q;
  assign drain_busy       = busy_q;
  assign drain_cnt        = cnt_q;
  assign flush_done       = flush_req && stb_empty && (state_q == DR_IDLE);

endmodule
